// File: rtl/entropy_pool_packer.sv
// Packs a raw serial TRNG bit stream into a left-aligned byte pool for the DF, with continuous health tests.
// Define ADAPTIVE_PROP_TEST_EN to build the adaptive proportion test next to the repetition count test.
module entropy_pool_packer #(
    parameter int unsigned POOL_BYTES = 48,
    parameter int unsigned RCT_CUTOFF = 21,
    parameter int unsigned APT_WINDOW = 1024,
    parameter int unsigned APT_CUTOFF = 589
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_i,
    input  logic                              bit_valid_i,
    input  logic                              bit_i,
    input  logic                              df_done_i,
    output logic                              df_start_o,
    output logic [$clog2(POOL_BYTES+1)-1:0]   df_len_bytes_o,
    output logic [8*POOL_BYTES-1:0]           df_bytes_o,
    output logic                              busy_o,
    output logic                              health_fail_o
);

    localparam int unsigned POOL_BITS = 8 * POOL_BYTES;
    localparam int unsigned LEN_W     = $clog2(POOL_BYTES + 1);
    localparam int unsigned CNT_W     = $clog2(POOL_BITS + 1);
    localparam int unsigned RUN_W     = $clog2(RCT_CUTOFF + 1);

    if (POOL_BYTES == 0 || RCT_CUTOFF < 2 || APT_CUTOFF > APT_WINDOW) begin : g_bad_params
        $error("entropy_pool_packer: invalid parameter set");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_DF = 3'd3,
        FAIL    = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   wr_idx_c;
    logic [LEN_W-1:0]   len_d;
    logic [RUN_W-1:0]   run_q, run_next_c;
    logic               prev_q;
    logic               accept_c;
    logic               clear_c;
    logic               rct_hit_c;
    logic               apt_hit_c;
    logic               health_hit_c;

    assign accept_c = (state_q == COLLECT) && bit_valid_i;

    // Repetition count: run length of the current value over accepted bits only.
    always_comb begin
        run_next_c = run_q;
        if (run_q == '0 || bit_i != prev_q) begin
            run_next_c = RUN_W'(1);
        end else if (run_q < RUN_W'(RCT_CUTOFF)) begin
            run_next_c = run_q + RUN_W'(1);
        end
        rct_hit_c = accept_c && (run_next_c >= RUN_W'(RCT_CUTOFF));
    end

`ifdef ADAPTIVE_PROP_TEST_EN
    localparam int unsigned WIN_W = $clog2(APT_WINDOW);
    localparam int unsigned APT_W = $clog2(APT_WINDOW + 1);

    logic [WIN_W-1:0] apt_pos_q;
    logic             apt_ref_q;
    logic [APT_W-1:0] apt_cnt_q, apt_cnt_next_c;

    // Adaptive proportion: first bit of each window is the reference and counts itself.
    always_comb begin
        apt_cnt_next_c = apt_cnt_q;
        if (apt_pos_q == '0) begin
            apt_cnt_next_c = APT_W'(1);
        end else if (bit_i == apt_ref_q) begin
            apt_cnt_next_c = apt_cnt_q + APT_W'(1);
        end
        apt_hit_c = accept_c && (apt_cnt_next_c >= APT_W'(APT_CUTOFF));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            apt_pos_q <= '0;
            apt_ref_q <= 1'b0;
            apt_cnt_q <= '0;
        end else if (accept_c) begin
            if (apt_pos_q == '0) begin
                apt_ref_q <= bit_i;
            end
            apt_cnt_q <= apt_cnt_next_c;
            apt_pos_q <= (apt_pos_q == WIN_W'(APT_WINDOW - 1)) ? '0 : apt_pos_q + WIN_W'(1);
        end
    end
`else
    assign apt_hit_c = 1'b0;
`endif

    assign health_hit_c = rct_hit_c || apt_hit_c;

    // Next state, pool bookkeeping and registered-output values.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        clear_c   = 1'b0;
        len_d     = '0;
        wr_idx_c  = CNT_W'(POOL_BITS - 1) - bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (health_hit_c) begin
                    state_d = FAIL;
                end else if (accept_c && bit_cnt_q == CNT_W'(POOL_BITS - 1)) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH:  state_d = WAIT_DF;
            WAIT_DF: begin
                if (df_done_i) begin
                    state_d = IDLE;
                end
            end
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
        endcase

        if (state_d == FAIL
            || (state_q == IDLE && state_d == COLLECT)
            || (state_q == WAIT_DF && state_d == IDLE)) begin
            clear_c   = 1'b1;
            bit_cnt_d = '0;
        end else if (accept_c) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        case (state_d)
            COLLECT:         len_d = LEN_W'(bit_cnt_d >> 3);
            LAUNCH, WAIT_DF: len_d = LEN_W'(POOL_BYTES);
            default:         len_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            run_q          <= '0;
            prev_q         <= 1'b0;
            df_bytes_o     <= '0;
            df_len_bytes_o <= '0;
            df_start_o     <= 1'b0;
            busy_o         <= 1'b0;
            health_fail_o  <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            df_len_bytes_o <= len_d;
            df_start_o     <= (state_d == LAUNCH);
            busy_o         <= (state_d != IDLE);
            health_fail_o  <= (state_d == FAIL);
            if (accept_c) begin
                run_q  <= run_next_c;
                prev_q <= bit_i;
            end
            if (clear_c) begin
                df_bytes_o <= '0;
            end else if (accept_c) begin
                df_bytes_o[wr_idx_c] <= bit_i;
            end
        end
    end

endmodule

// File: tb/tb_entropy_pool_packer.sv
// Scoreboarded bench for entropy_pool_packer: launches are checked by a monitor against queued expectations.
module tb_entropy_pool_packer;

    localparam int unsigned POOL_BYTES = 48;
    localparam int unsigned POOL_BITS  = 8 * POOL_BYTES;
    localparam int unsigned LEN_W      = $clog2(POOL_BYTES + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_i;
    logic                  bit_valid_i;
    logic                  bit_i;
    logic                  df_done_i;
    logic                  df_start_o;
    logic [LEN_W-1:0]      df_len_bytes_o;
    logic [POOL_BITS-1:0]  df_bytes_o;
    logic                  busy_o;
    logic                  health_fail_o;

    entropy_pool_packer dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req_i),
        .bit_valid_i    (bit_valid_i),
        .bit_i          (bit_i),
        .df_done_i      (df_done_i),
        .df_start_o     (df_start_o),
        .df_len_bytes_o (df_len_bytes_o),
        .df_bytes_o     (df_bytes_o),
        .busy_o         (busy_o),
        .health_fail_o  (health_fail_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LEN_W-1:0]     len;
        logic [POOL_BITS-1:0] bytes;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic bits [0:767];

    task automatic check(input string name, input logic [POOL_BITS-1:0] act, input logic [POOL_BITS-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the oldest queued pool.
    initial begin
        forever begin
            @(negedge clk);
            if (df_start_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_start: got df_start_o=1 want no launch");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("launch_bytes", df_bytes_o, e.bytes);
                    check("launch_len", POOL_BITS'(df_len_bytes_o), POOL_BITS'(e.len));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_i = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0; df_done_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_req();
        req_i = 1'b1;
        tick();
        req_i = 1'b0;
    endtask

    task automatic pulse_done();
        df_done_i = 1'b1;
        tick();
        df_done_i = 1'b0;
    endtask

    task automatic send_bits(input int from, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valid_i = 1'b1;
            bit_i       = bits[from + i];
            tick();
        end
        bit_valid_i = 1'b0;
    endtask

    task automatic fill_byte(input logic [7:0] b);
        for (int i = 0; i < 768; i++) bits[i] = b[7 - (i % 8)];
    endtask

    // Reference placement: bit n of a pool sits at [POOL_BITS-1-n].
    function automatic logic [POOL_BITS-1:0] model(input int from, input int n);
        logic [POOL_BITS-1:0] m;
        m = '0;
        for (int k = 0; k < n; k++) m[POOL_BITS - 1 - k] = bits[from + k];
        return m;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_start"}, POOL_BITS'(df_start_o), '0);
        check({tag, "_len"}, POOL_BITS'(df_len_bytes_o), '0);
        check({tag, "_bytes"}, df_bytes_o, '0);
        check({tag, "_busy"}, POOL_BITS'(busy_o), '0);
        check({tag, "_health"}, POOL_BITS'(health_fail_o), '0);
    endtask

    initial begin
        // Test 1: one pool of 0xA5 bytes.
        do_reset();
        check_zero_outputs("reset");
        fill_byte(8'hA5);
        pulse_req();
        check("t1_busy_collect", POOL_BITS'(busy_o), POOL_BITS'(1));
        exp_q.push_back('{len: LEN_W'(48), bytes: {48{8'hA5}}});
        send_bits(0, 383);
        check("t1_no_early_start", POOL_BITS'(df_start_o), '0);
        check("t1_len_383", POOL_BITS'(df_len_bytes_o), POOL_BITS'(47));
        send_bits(383, 1);
        check("t1_start", POOL_BITS'(df_start_o), POOL_BITS'(1));
        check("t1_len", POOL_BITS'(df_len_bytes_o), POOL_BITS'(48));
        check("t1_busy", POOL_BITS'(busy_o), POOL_BITS'(1));
        tick();
        check("t1_start_one_cycle", POOL_BITS'(df_start_o), '0);

        // Test 2: bits in WAIT_DF are dropped and do not feed the RCT.
        for (int i = 0; i < 50; i++) begin
            bit_valid_i = 1'b1;
            bit_i       = 1'b1;
            tick();
        end
        bit_valid_i = 1'b0;
        check("t2_hold_bytes", df_bytes_o, {48{8'hA5}});
        check("t2_hold_len", POOL_BITS'(df_len_bytes_o), POOL_BITS'(48));
        req_i = 1'b1;
        pulse_done();
        req_i = 1'b0;
        check("t2_clear_bytes", df_bytes_o, '0);
        check("t2_clear_len", POOL_BITS'(df_len_bytes_o), '0);
        check("t2_idle_busy", POOL_BITS'(busy_o), '0);
        tick();
        check("t2_req_with_done_ignored", POOL_BITS'(busy_o), '0);
        for (int i = 0; i < 384; i++) bits[i] = (i < 19) ? 1'b1 : ((i == 19) ? 1'b0 : 1'(i % 2));
        pulse_req();
        exp_q.push_back('{len: LEN_W'(48), bytes: model(0, 384)});
        send_bits(0, 384);
        check("t2_rct_continuity", POOL_BITS'(health_fail_o), '0);
        check("t2_second_start", POOL_BITS'(df_start_o), POOL_BITS'(1));
        tick();
        pulse_done();

        // Test 3: RCT boundary, 20 repeats pass, 21 fail.
        do_reset();
        for (int i = 0; i < 42; i++) bits[i] = (i == 20) ? 1'b0 : 1'b1;
        pulse_req();
        send_bits(0, 21);
        check("t3_run20_ok", POOL_BITS'(health_fail_o), '0);
        send_bits(21, 20);
        check("t3_run20b_ok", POOL_BITS'(health_fail_o), '0);
        send_bits(41, 1);
        check("t3_run21_fail", POOL_BITS'(health_fail_o), POOL_BITS'(1));
        check("t3_fail_busy", POOL_BITS'(busy_o), POOL_BITS'(1));
        check("t3_fail_bytes", df_bytes_o, '0);
        pulse_req();
        send_bits(0, 10);
        check("t3_sticky", POOL_BITS'(health_fail_o), POOL_BITS'(1));
        do_reset();
        check_zero_outputs("t3_rst");

        // Test 4: reset mid-collection aborts; next pool holds only new bits.
        fill_byte(8'hA5);
        pulse_req();
        send_bits(0, 100);
        check("t4_partial_len", POOL_BITS'(df_len_bytes_o), POOL_BITS'(12));
        check("t4_partial_bytes", df_bytes_o, model(0, 100));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero_outputs("t4_abort");
        fill_byte(8'h3C);
        pulse_req();
        exp_q.push_back('{len: LEN_W'(48), bytes: {48{8'h3C}}});
        send_bits(0, 384);
        check("t4_start", POOL_BITS'(df_start_o), POOL_BITS'(1));
        tick();
        pulse_done();

        // Test 5: 20x'1',1x'0' pattern across pools.
        do_reset();
        for (int i = 0; i < 768; i++) bits[i] = (i % 21 != 20);
        pulse_req();
        exp_q.push_back('{len: LEN_W'(48), bytes: model(0, 384)});
        send_bits(0, 384);
        tick();
        pulse_done();
        pulse_req();
`ifdef ADAPTIVE_PROP_TEST_EN
        send_bits(384, 233);
        check("t5_apt_588_ok", POOL_BITS'(health_fail_o), '0);
        send_bits(617, 1);
        check("t5_apt_fail", POOL_BITS'(health_fail_o), POOL_BITS'(1));
`else
        exp_q.push_back('{len: LEN_W'(48), bytes: model(384, 384)});
        send_bits(384, 384);
        check("t5_no_fail", POOL_BITS'(health_fail_o), '0);
        check("t5_second_start", POOL_BITS'(df_start_o), POOL_BITS'(1));
        tick();
        pulse_done();
`endif

        // Test 6: the 21st repeat is also the last pool bit.
        do_reset();
        for (int i = 0; i < 384; i++) bits[i] = (i < 363) ? 1'(i % 2) : 1'b1;
        pulse_req();
        send_bits(0, 384);
        check("t6_fail", POOL_BITS'(health_fail_o), POOL_BITS'(1));
        check("t6_no_start", POOL_BITS'(df_start_o), '0);
        tick();
        tick();
        check("t6_no_start_later", POOL_BITS'(df_start_o), '0);

        check("queue_drained", POOL_BITS'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
